// File: rtl/pe_col_dispatch_pkg.sv
// Shared types for the PE column task dispatcher.
package pe_col_dispatch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } dispatch_state_t;

  localparam int GM_W = 6;

endpackage

// File: rtl/pe_col_dispatch_if.sv
// Config, guard-map and task handshake bundle between the dispatcher and its neighbours.
interface pe_col_dispatch_if #(
  parameter int ROW_W = 8,
  parameter int GRP_W = 6
);
  import pe_col_dispatch_pkg::*;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [ROW_W-1:0] cfg_rows;
  logic [GRP_W-1:0] cfg_groups;
  logic             cfg_bit_mode;
  logic             cfg_kernel_mode;
  logic             gm_valid;
  logic             gm_ready;
  logic [GM_W-1:0]  gm_data;
  logic             ctrl_valid;
  logic             ctrl_ready;
  logic             ctrl_finish;
  logic [GM_W-1:0]  guard_map_o;
  logic             bit_mode_o;
  logic             kernel_mode_o;
  logic             is_odd_row_o;
  logic             end_of_row_o;
  logic             busy;
  logic             done;

  modport slave (
    input  cfg_valid, cfg_rows, cfg_groups, cfg_bit_mode, cfg_kernel_mode,
    input  gm_valid, gm_data, ctrl_ready, ctrl_finish,
    output cfg_ready, gm_ready, ctrl_valid, guard_map_o, bit_mode_o, kernel_mode_o,
    output is_odd_row_o, end_of_row_o, busy, done
  );

  modport master (
    output cfg_valid, cfg_rows, cfg_groups, cfg_bit_mode, cfg_kernel_mode,
    output gm_valid, gm_data, ctrl_ready, ctrl_finish,
    input  cfg_ready, gm_ready, ctrl_valid, guard_map_o, bit_mode_o, kernel_mode_o,
    input  is_odd_row_o, end_of_row_o, busy, done
  );

endinterface

// File: rtl/pe_col_dispatch.sv
// Walks rows x column groups of a layer, fetching one guard map per task and issuing it to the PE column.
// Optional build macro PE_DISPATCH_SKIP_ZERO_EN: zero guard maps that are not end-of-row are dropped in S_LOAD.
//
// state   | meaning
// S_IDLE  | waiting for a layer config (cfg_ready high)
// S_LOAD  | fetching the guard map for the current row/group
// S_ISSUE | task presented on ctrl_valid until accepted
// S_WAIT  | task in flight, waiting for ctrl_finish
// S_DONE  | one-cycle layer-complete pulse
module pe_col_dispatch
  import pe_col_dispatch_pkg::*;
#(
  parameter int ROW_W = 8,
  parameter int GRP_W = 6
) (
  input logic              clk,
  input logic              rst_n,
  pe_col_dispatch_if.slave bus
);

  dispatch_state_t  r_state;
  dispatch_state_t  w_next;
  logic [ROW_W-1:0] r_rows;
  logic [ROW_W-1:0] r_row_cnt;
  logic [GRP_W-1:0] r_groups;
  logic [GRP_W-1:0] r_grp_cnt;
  logic             r_bit_mode;
  logic             r_kernel_mode;
  logic [GM_W-1:0]  r_guard_map;
  logic             r_eor;
  logic             r_odd;
  logic             r_cfg_ready;
  logic             r_gm_ready;
  logic             r_ctrl_valid;
  logic             r_done;
  logic             r_busy;

  logic w_cfg_hs;
  logic w_gm_hs;
  logic w_ctrl_hs;
  logic w_fin;
  logic w_grp_last;
  logic w_row_last;
  logic w_skip;
  logic w_empty_cfg;

  assign w_cfg_hs    = bus.cfg_valid && r_cfg_ready;
  assign w_gm_hs     = bus.gm_valid && r_gm_ready;
  assign w_ctrl_hs   = r_ctrl_valid && bus.ctrl_ready;
  assign w_fin       = (r_state == S_WAIT) && bus.ctrl_finish;
  assign w_grp_last  = (r_grp_cnt == r_groups - GRP_W'(1));
  assign w_row_last  = (r_row_cnt == r_rows - ROW_W'(1));
  assign w_empty_cfg = (bus.cfg_rows == '0) || (bus.cfg_groups == '0);

`ifdef PE_DISPATCH_SKIP_ZERO_EN
  // End-of-row maps are always issued so the PE column still sees the row boundary.
  assign w_skip = (bus.gm_data == '0) && !r_bit_mode && !w_grp_last;
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_cfg_hs) w_next = w_empty_cfg ? S_DONE : S_LOAD;
      S_LOAD:  if (w_gm_hs && !w_skip) w_next = S_ISSUE;
      S_ISSUE: if (w_ctrl_hs) w_next = S_WAIT;
      S_WAIT:  if (w_fin) w_next = (w_grp_last && w_row_last) ? S_DONE : S_LOAD;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_rows        <= '0;
      r_row_cnt     <= '0;
      r_groups      <= '0;
      r_grp_cnt     <= '0;
      r_bit_mode    <= 1'b0;
      r_kernel_mode <= 1'b0;
      r_guard_map   <= '0;
      r_eor         <= 1'b0;
      r_odd         <= 1'b0;
      r_cfg_ready   <= 1'b1;
      r_gm_ready    <= 1'b0;
      r_ctrl_valid  <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cfg_ready  <= (w_next == S_IDLE);
      r_gm_ready   <= (w_next == S_LOAD);
      r_ctrl_valid <= (w_next == S_ISSUE);
      r_done       <= (w_next == S_DONE);
      r_busy       <= (w_next != S_IDLE);

      if (w_cfg_hs) begin
        r_rows        <= bus.cfg_rows;
        r_groups      <= bus.cfg_groups;
        r_bit_mode    <= bus.cfg_bit_mode;
        r_kernel_mode <= bus.cfg_kernel_mode;
        r_row_cnt     <= '0;
        r_grp_cnt     <= '0;
      end

      if (w_gm_hs) begin
        if (w_skip) begin
          r_grp_cnt <= r_grp_cnt + GRP_W'(1);
        end else begin
          r_guard_map <= bus.gm_data;
          r_eor       <= w_grp_last;
          r_odd       <= ~r_row_cnt[0];
        end
      end

      if (w_fin) begin
        if (w_grp_last) begin
          r_grp_cnt <= '0;
          r_row_cnt <= r_row_cnt + ROW_W'(1);
        end else begin
          r_grp_cnt <= r_grp_cnt + GRP_W'(1);
        end
      end
    end
  end

  assign bus.cfg_ready     = r_cfg_ready;
  assign bus.gm_ready      = r_gm_ready;
  assign bus.ctrl_valid    = r_ctrl_valid;
  assign bus.guard_map_o   = r_guard_map;
  assign bus.bit_mode_o    = r_bit_mode;
  assign bus.kernel_mode_o = r_kernel_mode;
  assign bus.is_odd_row_o  = r_odd;
  assign bus.end_of_row_o  = r_eor;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;

endmodule

// File: tb/tb_pe_col_dispatch.sv
// Scoreboard bench for pe_col_dispatch; honours PE_DISPATCH_SKIP_ZERO_EN when defined.
module tb_pe_col_dispatch;
  import pe_col_dispatch_pkg::*;

  localparam int ROW_W = 8;
  localparam int GRP_W = 6;
`ifdef PE_DISPATCH_SKIP_ZERO_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pe_col_dispatch_if #(.ROW_W(ROW_W), .GRP_W(GRP_W)) bus ();

  pe_col_dispatch #(.ROW_W(ROW_W), .GRP_W(GRP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];
  logic [5:0] gm_q[$];
  logic [5:0] stim_maps[$];
  int dones_exp = 0;
  int dones_seen = 0;
  int tasks_seen = 0;
  int ctrl_mode = 0;
  int fin_dly = 2;
  bit spur_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] out_vec();
    return {bus.cfg_ready, bus.gm_ready, bus.ctrl_valid, bus.busy, bus.done,
            bus.guard_map_o, bus.end_of_row_o, bus.is_odd_row_o, bus.bit_mode_o, bus.kernel_mode_o};
  endfunction

  // Reference: every (row, group) consumes one map; a task is expected unless the map is skippable.
  task automatic model_layer(input int rows, input int groups, input bit bm, input bit km);
    logic [5:0] m;
    bit eor, odd;
    for (int r = 0; r < rows; r++) begin
      for (int g = 0; g < groups; g++) begin
        m   = stim_maps[r * groups + g];
        eor = (g == groups - 1);
        odd = ((r + 1) % 2) == 1;
        gm_q.push_back(m);
        if (!(SKIP_EN && m == 6'd0 && !bm && !eor))
          exp_q.push_back({m, eor, odd, bm, km});
      end
    end
    dones_exp++;
  endtask

  task automatic wait_cfg_ready();
    bit ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (bus.cfg_ready) begin ok = 1'b1; break; end
    end
    chk("cfg_ready_wait", 32'(ok), 32'd1);
  endtask

  task automatic issue_layer(input int rows, input int groups, input bit bm, input bit km);
    wait_cfg_ready();
    @(posedge clk); #1;
    bus.cfg_valid       = 1'b1;
    bus.cfg_rows        = ROW_W'(rows);
    bus.cfg_groups      = GRP_W'(groups);
    bus.cfg_bit_mode    = bm;
    bus.cfg_kernel_mode = km;
    model_layer(rows, groups, bm, km);
    @(posedge clk); #1;
    bus.cfg_valid  = 1'b0;
    bus.cfg_rows   = ROW_W'($urandom);
    bus.cfg_groups = GRP_W'($urandom);
  endtask

  task automatic wait_layer();
    bit ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (dones_seen >= dones_exp) begin ok = 1'b1; break; end
    end
    chk("layer_done_wait", 32'(ok), 32'd1);
  endtask

  task automatic rand_maps(input int n, input bit allow_zero);
    logic [5:0] m;
    stim_maps.delete();
    for (int i = 0; i < n; i++) begin
      m = 6'($urandom);
      if (allow_zero && $urandom_range(0, 2) == 0) m = 6'd0;
      if (!allow_zero && m == 6'd0) m = 6'h15;
      stim_maps.push_back(m);
    end
  endtask

  // Guard-map source: random gm_valid, including while the DUT is not in S_LOAD.
  initial begin : gm_driver
    bit hs;
    bus.gm_valid = 1'b0;
    bus.gm_data  = '0;
    forever begin
      @(negedge clk);
      hs = bus.gm_valid && bus.gm_ready && rst_n;
      @(posedge clk); #1;
      if (hs && gm_q.size() > 0) void'(gm_q.pop_front());
      if (gm_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.gm_valid = 1'b1;
        bus.gm_data  = gm_q[0];
      end else begin
        bus.gm_valid = (gm_q.size() == 0) && ($urandom_range(0, 1) == 1);
        bus.gm_data  = 6'($urandom);
      end
    end
  end

  // PE column side: back-pressure on ctrl_ready, finish after fin_dly, optional stray finishes.
  initial begin : ctrl_driver
    bit xfer, vis;
    int lowcnt;
    lowcnt = 0;
    bus.ctrl_ready  = 1'b0;
    bus.ctrl_finish = 1'b0;
    forever begin
      @(negedge clk);
      xfer = bus.ctrl_valid && bus.ctrl_ready && rst_n;
      vis  = bus.ctrl_valid;
      @(posedge clk); #1;
      bus.ctrl_finish = 1'b0;
      if (xfer) begin
        bus.ctrl_ready = 1'b0;
        lowcnt = 0;
        repeat (fin_dly - 1) begin @(posedge clk); #1; end
        bus.ctrl_finish = 1'b1;
        @(posedge clk); #1;
        bus.ctrl_finish = 1'b0;
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        bus.ctrl_ready  = 1'b0;
        bus.ctrl_finish = 1'b1;
      end else begin
        case (ctrl_mode)
          0: bus.ctrl_ready = 1'b1;
          1: bus.ctrl_ready = ($urandom_range(0, 1) == 1);
          default: begin
            if (vis && lowcnt < 5) begin
              bus.ctrl_ready = 1'b0;
              lowcnt++;
            end else begin
              bus.ctrl_ready = vis;
            end
          end
        endcase
      end
    end
  end

  initial begin : monitor
    bit prev_stall, prev_done;
    logic [9:0] prev_f, f, e;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_f     = '0;
    forever begin
      @(negedge clk);
      f = {bus.guard_map_o, bus.end_of_row_o, bus.is_odd_row_o, bus.bit_mode_o, bus.kernel_mode_o};
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid_held", 32'(bus.ctrl_valid), 32'd1);
          chk("stall_fields_stable", 32'(f), 32'(prev_f));
        end
        if (bus.ctrl_valid && bus.ctrl_ready) begin
          tasks_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_task: got %0h expected no task", f);
          end else begin
            e = exp_q.pop_front();
            chk("task_fields", 32'(f), 32'(e));
          end
        end
        if (bus.done) begin
          chk("done_expected", 32'(dones_seen < dones_exp), 32'd1);
          chk("tasks_left_at_done", 32'(exp_q.size()), 32'd0);
          chk("done_one_cycle", 32'(prev_done), 32'd0);
          dones_seen++;
        end
        prev_stall = bus.ctrl_valid && !bus.ctrl_ready;
        prev_f     = f;
        prev_done  = bus.done;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0, d0, gm_cnt, done_at;
    bit ok;
    bus.cfg_valid       = 1'b0;
    bus.cfg_rows        = '0;
    bus.cfg_groups      = '0;
    bus.cfg_bit_mode    = 1'b0;
    bus.cfg_kernel_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(out_vec()), 32'h4000);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Two rows of three groups, all-ones maps, ready always high
    ctrl_mode = 0; fin_dly = 2; spur_en = 1'b0;
    stim_maps.delete();
    repeat (6) stim_maps.push_back(6'h3F);
    t0 = tasks_seen;
    issue_layer(2, 3, 1'b0, 1'b1);
    wait_layer();
    chk("basic_task_count", 32'(tasks_seen - t0), 32'd6);

    // Long back-pressure during S_ISSUE
    ctrl_mode = 2;
    rand_maps(2, 1'b0);
    t0 = tasks_seen;
    issue_layer(1, 2, 1'b1, 1'b0);
    wait_layer();
    chk("backpressure_task_count", 32'(tasks_seen - t0), 32'd2);

    // Empty layers: zero rows, then zero groups
    ctrl_mode = 0;
    for (int z = 0; z < 2; z++) begin
      wait_cfg_ready();
      @(posedge clk); #1;
      bus.cfg_valid  = 1'b1;
      bus.cfg_rows   = (z == 0) ? ROW_W'(0) : ROW_W'(3);
      bus.cfg_groups = (z == 0) ? GRP_W'(3) : GRP_W'(0);
      dones_exp++;
      @(posedge clk); #1;
      bus.cfg_valid = 1'b0;
      gm_cnt  = 0;
      done_at = 0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (bus.gm_ready) gm_cnt++;
        if (bus.done && done_at == 0) done_at = k;
      end
      chk("empty_layer_gm_ready", 32'(gm_cnt), 32'd0);
      chk("empty_layer_done_latency", 32'(done_at >= 1 && done_at <= 2), 32'd1);
    end

    // Zero maps: skippable ones dropped only when the skip feature is built in
    stim_maps.delete();
    stim_maps.push_back(6'h00); stim_maps.push_back(6'h00); stim_maps.push_back(6'h01);
    t0 = tasks_seen;
    issue_layer(1, 3, 1'b0, 1'b0);
    wait_layer();
    chk("zero_map_task_count", 32'(tasks_seen - t0), SKIP_EN ? 32'd1 : 32'd3);

    stim_maps.delete();
    repeat (3) stim_maps.push_back(6'h00);
    t0 = tasks_seen;
    issue_layer(1, 3, 1'b1, 1'b1);
    wait_layer();
    chk("zero_map_dense_task_count", 32'(tasks_seen - t0), 32'd3);

    // Randomized layers
    spur_en = 1'b1;
    for (int l = 0; l < 10; l++) begin
      int rows, groups;
      ctrl_mode = $urandom_range(0, 2);
      fin_dly   = $urandom_range(1, 4);
      rows      = $urandom_range(1, 3);
      groups    = $urandom_range(1, 4);
      rand_maps(rows * groups, 1'b1);
      issue_layer(rows, groups, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_layer();
    end
    spur_en = 1'b0;

    // Reset while a task is in flight
    ctrl_mode = 0; fin_dly = 8;
    rand_maps(4, 1'b0);
    t0 = tasks_seen;
    issue_layer(2, 2, 1'b1, 1'b1);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (tasks_seen > t0) begin ok = 1'b1; break; end
    end
    chk("reset_test_first_task", 32'(ok), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("reset_midtask_outputs", 32'(out_vec()), 32'h4000);
    exp_q.delete();
    gm_q.delete();
    dones_exp = dones_seen;
    d0 = dones_seen;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_done_after_reset", 32'(dones_seen), 32'(d0));
    chk("idle_after_reset", 32'(out_vec() & 15'h7800), 32'h4000);

    // Recovery layer
    fin_dly = 2;
    rand_maps(2, 1'b0);
    t0 = tasks_seen;
    issue_layer(2, 1, 1'b0, 1'b1);
    wait_layer();
    chk("recovery_task_count", 32'(tasks_seen - t0), 32'd2);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
